// File: rtl/regfile_sb.sv
// Parametrised register file with write-through bypass, a per-register pending
// scoreboard for multi-cycle producers, and two registered debug taps.
module regfile_sb #(
    parameter int n       = 8,
    parameter int NREG    = 8,
    parameter int ZERO_R0 = 1,
    parameter int TAP_A   = 2,
    parameter int TAP_B   = 3,
    localparam int AW     = $clog2(NREG),
    localparam int CW     = $clog2(NREG + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [n-1:0]         wdata,
    input  logic [AW-1:0]        raddr1,
    input  logic [AW-1:0]        raddr2,
    output logic signed [n-1:0]  rdata1,
    output logic signed [n-1:0]  rdata2,
    output logic                 busy1,
    output logic                 busy2,
    input  logic                 rsv,
    input  logic [AW-1:0]        rsv_addr,
    output logic                 rsv_ack,
    output logic [CW-1:0]        pending_cnt,
    output logic signed [n-1:0]  tap_a,
    output logic signed [n-1:0]  tap_b
);

    localparam logic [AW:0] NREG_W = (AW + 1)'(NREG);
    localparam bit          Z_R0   = (ZERO_R0 != 0);
    localparam bit          TA_OK  = (TAP_A >= 0) && (TAP_A < NREG);
    localparam bit          TB_OK  = (TAP_B >= 0) && (TAP_B < NREG);
    localparam int          TA_IDX = TA_OK ? TAP_A : 0;
    localparam int          TB_IDX = TB_OK ? TAP_B : 0;

    logic [n-1:0]    r_regs [0:NREG-1];
    logic [NREG-1:0] r_pend;
    logic [CW-1:0]   r_cnt;
    logic [n-1:0]    r_tap_a;
    logic [n-1:0]    r_tap_b;

    logic            w_wvalid;
    logic [NREG-1:0] w_pend_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [n-1:0]    w_tap_a_nxt;
    logic [n-1:0]    w_tap_b_nxt;

    // An address names real, writable storage: in range and not a hardwired r0.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < NREG_W) && !(Z_R0 && (a == '0));
    endfunction

    assign w_wvalid = we && addr_ok(waddr);

    always_comb begin
        rdata1 = '0;
        busy1  = 1'b0;
        if (addr_ok(raddr1)) begin
            if (w_wvalid && (waddr == raddr1)) begin
                rdata1 = wdata;
            end else begin
                rdata1 = r_regs[raddr1];
                busy1  = r_pend[raddr1];
            end
        end
    end

    always_comb begin
        rdata2 = '0;
        busy2  = 1'b0;
        if (addr_ok(raddr2)) begin
            if (w_wvalid && (waddr == raddr2)) begin
                rdata2 = wdata;
            end else begin
                rdata2 = r_regs[raddr2];
                busy2  = r_pend[raddr2];
            end
        end
    end

    // A writeback to the same register frees it for a new reservation this cycle.
    always_comb begin
        rsv_ack = 1'b0;
        if (rsv && addr_ok(rsv_addr)) begin
            rsv_ack = !r_pend[rsv_addr] || (w_wvalid && (waddr == rsv_addr));
        end
    end

    // Reservation is applied after the write so a same-cycle reserve wins.
    always_comb begin
        w_pend_nxt = r_pend;
        if (w_wvalid) begin
            w_pend_nxt[waddr] = 1'b0;
        end
        if (rsv_ack) begin
            w_pend_nxt[rsv_addr] = 1'b1;
        end
    end

    always_comb begin
        w_cnt_nxt = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            w_cnt_nxt = w_cnt_nxt + CW'(w_pend_nxt[i]);
        end
    end

    always_comb begin
        w_tap_a_nxt = '0;
        w_tap_b_nxt = '0;
        if (TA_OK) begin
            w_tap_a_nxt = (w_wvalid && (waddr == AW'(TA_IDX))) ? wdata : r_regs[TA_IDX];
        end
        if (TB_OK) begin
            w_tap_b_nxt = (w_wvalid && (waddr == AW'(TB_IDX))) ? wdata : r_regs[TB_IDX];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_regs  <= '{default: '0};
            r_pend  <= '0;
            r_cnt   <= '0;
            r_tap_a <= '0;
            r_tap_b <= '0;
        end else begin
            if (w_wvalid) begin
                r_regs[waddr] <= wdata;
            end
            r_pend  <= w_pend_nxt;
            r_cnt   <= w_cnt_nxt;
            r_tap_a <= w_tap_a_nxt;
            r_tap_b <= w_tap_b_nxt;
        end
    end

    assign pending_cnt = r_cnt;
    assign tap_a       = r_tap_a;
    assign tap_b       = r_tap_b;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb (NREG=6, n=16): expected values are queued when
// stimulus is applied and popped as each DUT output is sampled.
module tb_regfile_sb;

    localparam int N  = 16;
    localparam int NR = 6;
    localparam int AW = 3;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          we;
    logic [AW-1:0] waddr;
    logic [N-1:0]  wdata;
    logic [AW-1:0] raddr1, raddr2;
    logic [N-1:0]  rdata1, rdata2;
    logic          busy1, busy2;
    logic          rsv;
    logic [AW-1:0] rsv_addr;
    logic          rsv_ack;
    logic [CW-1:0] pending_cnt;
    logic [N-1:0]  tap_a, tap_b;

    regfile_sb #(.n(N), .NREG(NR), .ZERO_R0(1), .TAP_A(2), .TAP_B(3)) dut (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
        .busy1(busy1), .busy2(busy2), .rsv(rsv), .rsv_addr(rsv_addr),
        .rsv_ack(rsv_ack), .pending_cnt(pending_cnt), .tap_a(tap_a), .tap_b(tap_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t        sbq[$];
    int          total = 0;
    int          bad   = 0;
    logic [N-1:0] model [0:NR-1];

    task automatic push(input string tag, input logic [31:0] e);
        exp_t x;
        x.tag = tag;
        x.exp = e;
        sbq.push_back(x);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t x;
        total++;
        if (sbq.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty observed=%0h expected=<none>", obs);
        end else begin
            x = sbq.pop_front();
            assert (obs === x.exp) else begin
                bad++;
                $error("FAIL %s observed=%0h expected=%0h", x.tag, obs, x.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        raddr1 = '0; raddr2 = '0; rsv = 1'b0; rsv_addr = '0;
        for (int i = 0; i < NR; i++) model[i] = '0;
        tick(); tick();
        reset = 1'b0;
        #1;

        // Reset state over every encodable address, including out-of-range 6 and 7
        for (int a = 0; a < 8; a++) begin
            raddr1 = AW'(a); raddr2 = AW'(7 - a);
            #1;
            push("rst_rd1", 0);  pop_chk({16'h0, rdata1});
            push("rst_rd2", 0);  pop_chk({16'h0, rdata2});
            push("rst_busy", 0); pop_chk({30'h0, busy1, busy2});
        end
        push("rst_cnt", 0);   pop_chk({29'h0, pending_cnt});
        push("rst_tap_a", 0); pop_chk({16'h0, tap_a});
        push("rst_tap_b", 0); pop_chk({16'h0, tap_b});

        // r0 is hardwired: no bypass, write discarded
        we = 1'b1; waddr = 0; wdata = 16'h0055; raddr1 = 0;
        #1;
        push("r0_bypass", 0); pop_chk({16'h0, rdata1});
        tick(); we = 1'b0; #1;
        push("r0_after", 0); pop_chk({16'h0, rdata1});

        // r5 write: bypass on port 2, array on port 1 next cycle
        we = 1'b1; waddr = 5; wdata = 16'h0055; raddr2 = 5; raddr1 = 5;
        #1;
        push("r5_bypass", 16'h0055); pop_chk({16'h0, rdata2});
        push("r5_before", 0);        model[5] = 16'h0055;
        tick(); we = 1'b0; #1;
        pop_chk(0);
        push("r5_array", model[5]); pop_chk({16'h0, rdata1});

        // Bypass of a negative value to r3 and tap_b update
        we = 1'b1; waddr = 3; wdata = 16'hFFA7; raddr1 = 3;
        #1;
        push("r3_bypass", 16'hFFA7); pop_chk({16'h0, rdata1});
        push("tap_b_pre", 0);        pop_chk({16'h0, tap_b});
        model[3] = 16'hFFA7;
        tick(); we = 1'b0; #1;
        push("tap_b_post", model[3]); pop_chk({16'h0, tap_b});
        push("r3_array", model[3]);   pop_chk({16'h0, rdata1});
        assert ($signed(rdata1) == -89) else begin
            bad++; $error("FAIL r3_signed observed=%0d expected=-89", $signed(rdata1));
        end
        total++;

        // Reserve r4, re-reserve refused, writeback clears
        rsv = 1'b1; rsv_addr = 4; raddr1 = 4;
        #1;
        push("r4_ack", 1);       pop_chk({31'h0, rsv_ack});
        push("r4_busy_pre", 0);  pop_chk({31'h0, busy1});
        tick(); #1;
        push("r4_reack", 0);     pop_chk({31'h0, rsv_ack});
        push("r4_busy", 1);      pop_chk({31'h0, busy1});
        push("r4_cnt", 1);       pop_chk({29'h0, pending_cnt});
        rsv = 1'b0;
        tick();
        push("r4_cnt_hold", 1);  pop_chk({29'h0, pending_cnt});
        we = 1'b1; waddr = 4; wdata = 16'h0012;
        #1;
        push("r4_wb_busy", 0);   pop_chk({31'h0, busy1});
        push("r4_wb_data", 16'h0012); pop_chk({16'h0, rdata1});
        model[4] = 16'h0012;
        tick(); we = 1'b0; #1;
        push("r4_cnt_clr", 0);   pop_chk({29'h0, pending_cnt});
        push("r4_busy_clr", 0);  pop_chk({31'h0, busy1});

        // r1 pending, then same-cycle write and reserve
        rsv = 1'b1; rsv_addr = 1; raddr1 = 1;
        tick(); rsv = 1'b0; #1;
        push("r1_cnt", 1);       pop_chk({29'h0, pending_cnt});
        we = 1'b1; waddr = 1; wdata = 16'h0030; rsv = 1'b1; rsv_addr = 1;
        #1;
        push("sim_ack", 1);      pop_chk({31'h0, rsv_ack});
        push("sim_busy", 0);     pop_chk({31'h0, busy1});
        model[1] = 16'h0030;
        tick(); we = 1'b0; rsv = 1'b0; #1;
        push("sim_data", model[1]); pop_chk({16'h0, rdata1});
        push("sim_busy_post", 1);   pop_chk({31'h0, busy1});
        push("sim_cnt", 1);         pop_chk({29'h0, pending_cnt});

        // Refused reservations: r0 and out-of-range
        rsv = 1'b1; rsv_addr = 0; #1;
        push("rsv_r0", 0);  pop_chk({31'h0, rsv_ack});
        rsv_addr = 7; #1;
        push("rsv_r7", 0);  pop_chk({31'h0, rsv_ack});
        tick(); rsv = 1'b0; #1;
        push("rsv_ref_cnt", 1); pop_chk({29'h0, pending_cnt});

        // Out-of-range writes change nothing
        we = 1'b1; waddr = 7; wdata = 16'hBEEF; raddr2 = 7;
        #1;
        push("oor_rd2", 0);  pop_chk({16'h0, rdata2});
        push("oor_busy2", 0); pop_chk({31'h0, busy2});
        tick(); waddr = 6; tick(); we = 1'b0;
        for (int a = 1; a < NR; a++) begin
            raddr2 = AW'(a); #1;
            push("oor_array", model[a]); pop_chk({16'h0, rdata2});
        end

        // tap_a follows r2
        we = 1'b1; waddr = 2; wdata = 16'h1234; model[2] = 16'h1234;
        tick(); we = 1'b0; #1;
        push("tap_a_post", model[2]); pop_chk({16'h0, tap_a});

        // Reserve r2..r5 (r1 already pending)
        for (int a = 2; a < NR; a++) begin
            rsv = 1'b1; rsv_addr = AW'(a); #1;
            push("fill_ack", 1); pop_chk({31'h0, rsv_ack});
            tick();
        end
        rsv = 1'b0; #1;
        push("fill_cnt", 5); pop_chk({29'h0, pending_cnt});
        for (int a = 1; a < NR; a++) begin
            raddr2 = AW'(a); #1;
            push("fill_busy", 1); pop_chk({31'h0, busy2});
        end

        // Asynchronous reset between edges
        raddr1 = 2; raddr2 = 3;
        #2 reset = 1'b1;
        #1;
        push("arst_cnt", 0);   pop_chk({29'h0, pending_cnt});
        push("arst_tap_a", 0); pop_chk({16'h0, tap_a});
        push("arst_tap_b", 0); pop_chk({16'h0, tap_b});
        push("arst_busy", 0);  pop_chk({30'h0, busy1, busy2});
        push("arst_rd1", 0);   pop_chk({16'h0, rdata1});
        rsv = 1'b1; rsv_addr = 2; #1;
        push("arst_ack", 1);   pop_chk({31'h0, rsv_ack});
        tick();
        reset = 1'b0; rsv = 1'b0; #1;
        push("arst_hold_cnt", 0); pop_chk({29'h0, pending_cnt});
        tick();
        push("arst_post_cnt", 0); pop_chk({29'h0, pending_cnt});

        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
